chrono_counter: RTL

Parametrised stopwatch/timer core for the chronometer datapath. It counts hours:minutes:seconds:milliseconds up from zero or down from a loaded preset. The millisecond rate comes from an internal prescaler on the system clock. The block adds lap capture, countdown expiry and overflow flags, and sits between the input/state logic (run, clear, lap requests) and the display/BCD conversion stage.

---
 rtl/chrono_counter.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/chrono_counter.sv
// chrono_counter -- stopwatch / countdown timer core (h:m:s.ms).
//
// A prescaler divides clk down to a millisecond tick. Time counts up from zero
// or down from a loaded preset. The block provides lap capture, sticky
// countdown-expiry and sticky up-count-overflow flags.
//
// Optional feature macro: CHRONO_LAP_EN
//   defined   -> lap capture registers are implemented
//   undefined -> lap is ignored and lap_* read 0 (the ports are kept)
//
// Parameters
//   CLK_PER_MS : system clocks per millisecond (>= 2)
//   HOURS_W    : hours field width; hours run 0 .. 2^HOURS_W-1
// Ports
//   clk, reset_n            : clock (rising edge) and async active-low reset
//   run                     : count enable (0 freezes the prescaler)
//   clear                   : sync clear of time, prescaler and flags
//   mode                    : 0 = up, 1 = down (sampled on each tick)
//   load, preset_h/m/s      : sync load of preset time (m/s saturate at 59)
//   lap                     : single-cycle lap capture request
//   hours/minutes/seconds/milliseconds : current time
//   lap_h/m/s/ms            : captured lap time
//   ms_tick                 : one-cycle pulse aligned with each time update
//   expired, overflow       : sticky status flags
module chrono_counter #(
   parameter int CLK_PER_MS = 50000,
   parameter int HOURS_W    = 4
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               run,
   input  logic               clear,
   input  logic               mode,
   input  logic               load,
   input  logic [HOURS_W-1:0] preset_h,
   input  logic [5:0]         preset_m,
   input  logic [5:0]         preset_s,
   input  logic               lap,
   output logic [HOURS_W-1:0] hours,
   output logic [5:0]         minutes,
   output logic [5:0]         seconds,
   output logic [9:0]         milliseconds,
   output logic [HOURS_W-1:0] lap_h,
   output logic [5:0]         lap_m,
   output logic [5:0]         lap_s,
   output logic [9:0]         lap_ms,
   output logic               ms_tick,
   output logic               expired,
   output logic               overflow
);

   localparam int PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
   localparam logic [PW-1:0]      PRESC_MAX = PW'(CLK_PER_MS - 1);
   localparam logic [HOURS_W-1:0] H_MAX     = '1;

   typedef struct packed {
      logic [HOURS_W-1:0] h;
      logic [5:0]         m;
      logic [5:0]         s;
      logic [9:0]         ms;
   } time_t;

   time_t         time_q, time_d, time_inc, time_dec;
   logic [PW-1:0] presc_q, presc_d;
   logic          expired_q, expired_d;
   logic          overflow_q, overflow_d;
   logic          ms_tick_q, ms_tick_d;
   logic          tick, time_zero, wrap;

   assign tick      = run & ~expired_q & (presc_q == PRESC_MAX);
   assign time_zero = (time_q == '0);

   // Up-count successor with field-wise carries; wrap flags the rollover
   // from the maximum representable time back to zero.
   always_comb begin
      time_inc = time_q;
      wrap     = 1'b0;
      if (time_q.ms == 10'd999) begin
         time_inc.ms = '0;
         if (time_q.s == 6'd59) begin
            time_inc.s = '0;
            if (time_q.m == 6'd59) begin
               time_inc.m = '0;
               if (time_q.h == H_MAX) begin
                  time_inc.h = '0;
                  wrap       = 1'b1;
               end else begin
                  time_inc.h = time_q.h + 1'b1;
               end
            end else begin
               time_inc.m = time_q.m + 6'd1;
            end
         end else begin
            time_inc.s = time_q.s + 6'd1;
         end
      end else begin
         time_inc.ms = time_q.ms + 10'd1;
      end
   end

   // Down-count predecessor. Only used when the time is non-zero, so the
   // hours decrement never underflows.
   always_comb begin
      time_dec = time_q;
      if (time_q.ms == 10'd0) begin
         time_dec.ms = 10'd999;
         if (time_q.s == 6'd0) begin
            time_dec.s = 6'd59;
            if (time_q.m == 6'd0) begin
               time_dec.m = 6'd59;
               time_dec.h = time_q.h - 1'b1;
            end else begin
               time_dec.m = time_q.m - 6'd1;
            end
         end else begin
            time_dec.s = time_q.s - 6'd1;
         end
      end else begin
         time_dec.ms = time_q.ms - 10'd1;
      end
   end

   // Priority: clear > load > tick.
   always_comb begin
      time_d     = time_q;
      presc_d    = presc_q;
      expired_d  = expired_q;
      overflow_d = overflow_q;
      ms_tick_d  = 1'b0;
      if (clear) begin
         time_d     = '0;
         presc_d    = '0;
         expired_d  = 1'b0;
         overflow_d = 1'b0;
      end else if (load) begin
         time_d.h   = preset_h;
         time_d.m   = (preset_m > 6'd59) ? 6'd59 : preset_m;
         time_d.s   = (preset_s > 6'd59) ? 6'd59 : preset_s;
         time_d.ms  = '0;
         presc_d    = '0;
         expired_d  = 1'b0;
         overflow_d = 1'b0;
      end else begin
         if (run && !expired_q)
            presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + 1'b1;
         if (tick) begin
            if (mode) begin
               // A tick at zero only raises expired; the time stays at zero.
               if (time_zero) begin
                  expired_d = 1'b1;
               end else begin
                  time_d    = time_dec;
                  ms_tick_d = 1'b1;
               end
            end else begin
               time_d    = time_inc;
               ms_tick_d = 1'b1;
               if (wrap) overflow_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         time_q     <= '0;
         presc_q    <= '0;
         expired_q  <= 1'b0;
         overflow_q <= 1'b0;
         ms_tick_q  <= 1'b0;
      end else begin
         time_q     <= time_d;
         presc_q    <= presc_d;
         expired_q  <= expired_d;
         overflow_q <= overflow_d;
         ms_tick_q  <= ms_tick_d;
      end
   end

`ifdef CHRONO_LAP_EN
   time_t lap_q, lap_d;

   // Captures the pre-edge time, so a coincident tick or clear is not seen.
   always_comb begin
      lap_d = lap_q;
      if (lap) lap_d = time_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) lap_q <= '0;
      else          lap_q <= lap_d;
   end

   assign lap_h  = lap_q.h;
   assign lap_m  = lap_q.m;
   assign lap_s  = lap_q.s;
   assign lap_ms = lap_q.ms;
`else
   logic unused_lap;
   assign unused_lap = lap;
   assign lap_h  = '0;
   assign lap_m  = '0;
   assign lap_s  = '0;
   assign lap_ms = '0;
`endif

   assign hours        = time_q.h;
   assign minutes      = time_q.m;
   assign seconds      = time_q.s;
   assign milliseconds = time_q.ms;
   assign ms_tick      = ms_tick_q;
   assign expired      = expired_q;
   assign overflow     = overflow_q;

endmodule
